fd_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the fetch/decode boundary of the 16-bit WISC pipeline. Each cycle it decides whether the PC advances, whether the fetch/decode register loads, holds or is squashed to a NOP, and whether a bubble is injected into decode/execute. It resolves instruction-memory wait states, load-use hazards, EX-stage redirects (including redirects that arrive while a fetch is outstanding) and HALT drain. It also keeps an optional stall-cycle counter.

---
 rtl/fd_pipe_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fd_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fd_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// fd_pipe_ctrl
//
// Sequencing controller for the fetch/decode boundary of the 16-bit WISC
// pipeline. Every cycle it decides whether the PC advances, whether the
// fetch/decode register loads, holds or is squashed to a NOP, and whether a
// bubble enters decode/execute. It handles instruction-memory wait states,
// load-use hazards, EX-stage redirects (including a redirect that lands while
// a fetch is still outstanding) and HALT drain.
//
// Outputs are Mealy: they depend on the current state and this cycle's
// inputs, with no added latency.
//
// Optional feature (macro FD_STALL_CNT_EN):
//   defined   - saturating stall-cycle counter drives stall_cnt
//   undefined - no counter flops, stall_cnt tied to zero
//
// Parameters:
//   NOP_INSTR    instruction loaded into fetch/decode on a squash
//   CNT_W        width of the stall counter
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   imem_ready     instruction memory returns a valid fetch this cycle
//   redirect_ex    taken branch/jump resolved in EX
//   idex_mem_read  instruction in decode/execute is a load
//   idex_rd        destination register of that load
//   fd_rs, fd_rt   source registers of the instruction in decode
//   fd_rs_valid,
//   fd_rt_valid    matching source is actually read
//   halt_dec       instruction in decode is HALT
//   pc_en          PC write enable
//   fd_en          fetch/decode register write enable
//   fd_flush       select fd_nop as the fetch/decode register input
//   fd_nop         constant NOP_INSTR for the fetch/decode input mux
//   de_bubble      zero the control bits entering decode/execute
//   halted         processor halted
//   stall_cnt      stall-cycle count
// ----------------------------------------------------------------------------
module fd_pipe_ctrl #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             redirect_ex,
    input  logic             idex_mem_read,
    input  logic [2:0]       idex_rd,
    input  logic [2:0]       fd_rs,
    input  logic [2:0]       fd_rt,
    input  logic             fd_rs_valid,
    input  logic             fd_rt_valid,
    input  logic             halt_dec,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic [15:0]      fd_nop,
    output logic             de_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        SQUASH   = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   lu;

    assign fd_nop = NOP_INSTR;

    // Load in EX writes a register that decode is about to read.
    assign lu = idex_mem_read &
                ((fd_rs_valid & (idex_rd == fd_rs)) |
                 (fd_rt_valid & (idex_rd == fd_rt)));

    // ------------------------------------------------------------------
    // Decision logic: outputs and next state from state + inputs.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_nxt = state;
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        halted    = 1'b0;

        if (rst) begin
            // Hold the front end quiet while reset is asserted; any
            // pending squash is simply forgotten.
            state_nxt = RUN;
            pc_en     = 1'b0;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (redirect_ex) begin
                        fd_flush  = 1'b1;
                        de_bubble = 1'b1;
                        // Wrong-path fetch still in flight: wait it out.
                        state_nxt = imem_ready ? RUN : SQUASH;
                    end else if (lu) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        de_bubble = 1'b1;
                        state_nxt = imem_ready ? state : MEM_WAIT;
                    end else if (!imem_ready) begin
                        pc_en     = 1'b0;
                        fd_flush  = 1'b1;
                        state_nxt = MEM_WAIT;
                    end else if (halt_dec) begin
                        // HALT itself moves on; nothing behind it enters.
                        pc_en     = 1'b0;
                        fd_flush  = 1'b1;
                        state_nxt = HALTED;
                    end else begin
                        state_nxt = RUN;
                    end
                end

                SQUASH: begin
                    if (redirect_ex) begin
                        fd_flush  = 1'b1;
                        de_bubble = 1'b1;
                        state_nxt = SQUASH;
                    end else begin
                        // Wrong-path data is dropped whenever it returns;
                        // the PC already holds the target, so it is
                        // refetched rather than advanced.
                        pc_en     = 1'b0;
                        fd_flush  = 1'b1;
                        state_nxt = imem_ready ? RUN : SQUASH;
                    end
                end

                HALTED: begin
                    pc_en     = 1'b0;
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                    halted    = 1'b1;
                    state_nxt = HALTED;
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values; the comb block above uses blocking.
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Optional stall counter.
    // ------------------------------------------------------------------
`ifdef FD_STALL_CNT_EN
    logic             stall;
    logic [CNT_W-1:0] cnt_q;

    // A halted core is idle, not stalled.
    assign stall = ~pc_en & (state != HALTED) & ~rst;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fd_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fd_pipe_ctrl
//
// Directed bench for fd_pipe_ctrl. Inputs change on the falling edge; the
// Mealy outputs are sampled 1 ns later, well away from the rising edge that
// commits the state. Output vector order: {pc_en, fd_en, fd_flush,
// de_bubble, halted}. The DUT is built with CNT_W=4 so counter saturation is
// reachable; expected counts collapse to 0 when FD_STALL_CNT_EN is undefined.
// ----------------------------------------------------------------------------
module tb_fd_pipe_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             imem_ready;
    logic             redirect_ex;
    logic             idex_mem_read;
    logic [2:0]       idex_rd;
    logic [2:0]       fd_rs;
    logic [2:0]       fd_rt;
    logic             fd_rs_valid;
    logic             fd_rt_valid;
    logic             halt_dec;
    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic [15:0]      fd_nop;
    logic             de_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Expected output vectors {pc_en, fd_en, fd_flush, de_bubble, halted}.
    localparam logic [4:0] O_NORM   = 5'b11000;
    localparam logic [4:0] O_RST    = 5'b01110;
    localparam logic [4:0] O_LU     = 5'b00010;
    localparam logic [4:0] O_WAIT   = 5'b01100;
    localparam logic [4:0] O_REDIR  = 5'b11110;
    localparam logic [4:0] O_HALTED = 5'b01111;
    localparam logic [4:0] M_ALL    = 5'b11111;
    // SQUASH waits: de_bubble is left unchecked there.
    localparam logic [4:0] M_SQ     = 5'b11101;
    localparam logic [4:0] O_SQ     = 5'b01100;

    fd_pipe_ctrl #(
        .NOP_INSTR (16'h0800),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_ready    (imem_ready),
        .redirect_ex   (redirect_ex),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .fd_rs         (fd_rs),
        .fd_rt         (fd_rt),
        .fd_rs_valid   (fd_rs_valid),
        .fd_rt_valid   (fd_rt_valid),
        .halt_dec      (halt_dec),
        .pc_en         (pc_en),
        .fd_en         (fd_en),
        .fd_flush      (fd_flush),
        .fd_nop        (fd_nop),
        .de_bubble     (de_bubble),
        .halted        (halted),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ec(input int n);
`ifdef FD_STALL_CNT_EN
        return (n > 15) ? 15 : n;
`else
        return 0;
`endif
    endfunction

    task automatic idle();
        rst           = 1'b0;
        imem_ready    = 1'b1;
        redirect_ex   = 1'b0;
        idex_mem_read = 1'b0;
        idex_rd       = 3'd0;
        fd_rs         = 3'd0;
        fd_rt         = 3'd0;
        fd_rs_valid   = 1'b0;
        fd_rt_valid   = 1'b0;
        halt_dec      = 1'b0;
    endtask

    // Sample this cycle's outputs (inputs already driven after a negedge),
    // optionally the counter (exp_cnt < 0 skips it), then move to the next
    // falling edge.
    task automatic cyc(input string tag, input logic [4:0] exp,
                       input logic [4:0] mask, input int exp_cnt);
        #1;
        check(tag, 32'({pc_en, fd_en, fd_flush, de_bubble, halted} & mask),
              32'(exp & mask));
        if (exp_cnt >= 0)
            check({tag, "_cnt"}, 32'(stall_cnt), 32'(ec(exp_cnt)));
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);

        // Reset behaviour.
        cyc("rst0", O_RST, M_ALL, -1);
        check("fd_nop", 32'(fd_nop), 32'h0800);
        rst = 1'b1;
        cyc("rst1", O_RST, M_ALL, -1);

        // Normal flow.
        idle();
        for (int i = 0; i < 4; i++) cyc("norm", O_NORM, M_ALL, 0);

        // Load-use through rs.
        idex_mem_read = 1'b1; idex_rd = 3'd3; fd_rs = 3'd3; fd_rs_valid = 1'b1;
        cyc("lu_rs", O_LU, M_ALL, 0);
        idle();
        cyc("after_lu", O_NORM, M_ALL, 1);

        // Matching rs that is not read, non-matching rt: no hazard.
        idex_mem_read = 1'b1; idex_rd = 3'd2; fd_rs = 3'd2; fd_rs_valid = 1'b0;
        fd_rt = 3'd1; fd_rt_valid = 1'b1;
        cyc("lu_none", O_NORM, M_ALL, 1);

        // Load-use through rt.
        idex_mem_read = 1'b1; idex_rd = 3'd5; fd_rt = 3'd5; fd_rt_valid = 1'b1;
        cyc("lu_rt", O_LU, M_ALL, 1);
        idle();
        cyc("after_lu_rt", O_NORM, M_ALL, 2);

        // Instruction memory wait, three cycles.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("memwait", O_WAIT, M_ALL, 2 + i);
        idle();
        cyc("memwait_done", O_NORM, M_ALL, 5);

        // Load-use with fetch not ready goes to MEM_WAIT, then resolves.
        imem_ready = 1'b0;
        idex_mem_read = 1'b1; idex_rd = 3'd4; fd_rs = 3'd4; fd_rs_valid = 1'b1;
        cyc("lu_wait", O_LU, M_ALL, 5);
        idle();
        cyc("mw_normal", O_NORM, M_ALL, 6);

        // Redirect while fetch outstanding, ready after two cycles.
        redirect_ex = 1'b1; imem_ready = 1'b0;
        cyc("redir_wait", O_REDIR, M_ALL, 6);
        redirect_ex = 1'b0;
        cyc("sq_wait", O_SQ, M_SQ, 6);
        imem_ready = 1'b1;
        cyc("sq_return", O_SQ, M_SQ, 7);
        cyc("sq_done", O_NORM, M_ALL, 8);

        // Redirect arriving while already in SQUASH stays in SQUASH.
        redirect_ex = 1'b1; imem_ready = 1'b0;
        cyc("redir_a", O_REDIR, M_ALL, 8);
        imem_ready = 1'b1;
        cyc("redir_in_sq", O_REDIR, M_ALL, 8);
        redirect_ex = 1'b0;
        cyc("sq_return2", O_SQ, M_SQ, 8);
        cyc("sq_done2", O_NORM, M_ALL, 9);

        // Redirect outranks load-use; with ready it returns straight to RUN.
        redirect_ex = 1'b1;
        idex_mem_read = 1'b1; idex_rd = 3'd6; fd_rs = 3'd6; fd_rs_valid = 1'b1;
        cyc("redir_over_lu", O_REDIR, M_ALL, 9);
        idle();
        cyc("redir_run", O_NORM, M_ALL, 9);

        // HALT waits behind a memory wait, then is accepted.
        halt_dec = 1'b1; imem_ready = 1'b0;
        cyc("halt_wait", O_WAIT, M_ALL, 9);
        imem_ready = 1'b1;
        cyc("halt_accept", O_WAIT, M_ALL, 10);
        // Halted: everything ignored.
        halt_dec = 1'b0;
        redirect_ex = 1'b1;
        cyc("halted_redir", O_HALTED, M_ALL, 11);
        redirect_ex = 1'b0;
        idex_mem_read = 1'b1; idex_rd = 3'd1; fd_rs = 3'd1; fd_rs_valid = 1'b1;
        cyc("halted_lu", O_HALTED, M_ALL, 11);
        idle();
        imem_ready = 1'b0;
        cyc("halted_wait", O_HALTED, M_ALL, 11);

        // Reset leaves HALTED.
        rst = 1'b1;
        cyc("rst_halt", O_RST, M_ALL, -1);
        idle();
        cyc("post_halt", O_NORM, M_ALL, 0);

        // Reset in the middle of SQUASH forgets the squash.
        redirect_ex = 1'b1; imem_ready = 1'b0;
        cyc("redir_pre_rst", O_REDIR, M_ALL, 0);
        redirect_ex = 1'b0; rst = 1'b1;
        cyc("rst_sq", O_RST, M_ALL, -1);
        idle();
        cyc("post_sq_rst", O_NORM, M_ALL, 0);

        // Twenty stall cycles: counter saturates at 15.
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) cyc("sat", O_WAIT, M_ALL, i);
        idle();
        cyc("sat_done", O_NORM, M_ALL, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
